// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and defaults for the PE array controller.
// Holds the FSM state encoding, the delay-line entry that carries a row
// issue down to the psum write port, and the default geometry constants.
package pe_array_ctrl_pkg;

    localparam int DEF_IMG_H    = 64;
    localparam int DEF_CH       = 1;
    localparam int DEF_PIPE_LAT = 3;

    // Row field in the delay-line entry is sized for the largest supported
    // image; the top truncates it to its own address width.
    localparam int ROW_W_MAX = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // One row issue travelling through the array latency.
    typedef struct packed {
        logic                 valid;
        logic [ROW_W_MAX-1:0] row;
        logic                 acc;
    } issue_t;

endpackage

// File: rtl/pe_array_ctrl_delay.sv
// ctrl_delay_line: fixed-depth shift register that delays each row issue by
// exactly DEPTH cycles so the psum write lines up with the array result.
module ctrl_delay_line
    import pe_array_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LAT
) (
    input  logic   clk,
    input  logic   rst,
    input  issue_t din,
    output issue_t dout
);

    issue_t stage [DEPTH];

    // Shift the entry one stage per cycle; stage DEPTH-1 is the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the stages are reset (not just the valid bits left to
            // drain) so an aborted pass can never emit a late psum write.
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequences one layer pass over a row-stationary PE array.
// Per channel: load filter/bias, stream IMG_H-2 triple-row reads, then wait
// PIPE_LAT cycles for the last results to be written to the psum buffer.
// Optional feature: define DONE_IRQ_EN to add a sticky completion interrupt
// (ports irq_clr/irq); without it those ports and their logic are absent.
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
#(
    parameter int IMG_H    = DEF_IMG_H,
    parameter int CH       = DEF_CH,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    w_load,
    output logic [$clog2(CH):0]     w_ch,
    output logic                    if_rd_en,
    output logic [$clog2(IMG_H)-1:0] if_row_addr,
    output logic                    ps_we,
    output logic [$clog2(IMG_H)-1:0] ps_row_addr,
    output logic                    ps_acc,
    output logic                    busy,
    output logic                    done
`ifdef DONE_IRQ_EN
    ,
    input  logic                    irq_clr,
    output logic                    irq
`endif
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int CH_W  = $clog2(CH) + 1;
    localparam int LAT_W = $clog2(PIPE_LAT + 1);
    localparam int NROW  = IMG_H - 2;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NROW - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIPE_LAT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);

    state_t           state;
    logic [ROW_W-1:0] row_cnt;
    logic [CH_W-1:0]  ch_cnt;
    logic [LAT_W-1:0] lat_cnt;

    issue_t issue_in;
    issue_t issue_out;
    logic   unused_row_bits;

    // Pass sequencer: every counter terminal value forces a state exit, so
    // none of them can wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state   <= ST_IDLE;
            row_cnt <= '0;
            ch_cnt  <= '0;
            lat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_LOAD_W;
                        ch_cnt <= '0;
                    end
                end
                ST_LOAD_W: begin
                    state   <= ST_STREAM;
                    row_cnt <= '0;
                end
                ST_STREAM: begin
                    if (row_cnt == ROW_LAST) begin
                        state   <= ST_DRAIN;
                        row_cnt <= '0;
                        lat_cnt <= '0;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt <= '0;
                        if (ch_cnt == CH_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            state  <= ST_LOAD_W;
                            ch_cnt <= ch_cnt + 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Clearing here keeps w_ch at 0 throughout IDLE.
                    state  <= ST_IDLE;
                    ch_cnt <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // State-decoded strobes and the entry pushed into the delay line.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned and infers a latch.
        w_load      = 1'b0;
        if_rd_en    = 1'b0;
        if_row_addr = '0;
        busy        = (state != ST_IDLE);
        done        = 1'b0;
        w_ch        = ch_cnt;
        issue_in    = '0;
        case (state)
            ST_LOAD_W: w_load = 1'b1;
            ST_STREAM: begin
                if_rd_en       = 1'b1;
                if_row_addr    = row_cnt;
                issue_in.valid = 1'b1;
                issue_in.row   = ROW_W_MAX'(row_cnt);
                issue_in.acc   = (ch_cnt != '0);
            end
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
    end

    ctrl_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (issue_in),
        .dout (issue_out)
    );

    // Psum write port comes straight off the delayed entry; address and acc
    // are forced to 0 whenever no write is in progress.
    always_comb begin
        ps_we       = issue_out.valid;
        ps_row_addr = issue_out.valid ? issue_out.row[ROW_W-1:0] : '0;
        ps_acc      = issue_out.valid & issue_out.acc;
    end

    // Upper row bits are always zero for this IMG_H.
    assign unused_row_bits = ^issue_out.row;

`ifdef DONE_IRQ_EN
    // Sticky completion interrupt: set on done, cleared by irq_clr, set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_H, default 64, giving the ifmap rows per channel (must be >= 3).
REQ-002 The block SHALL have parameter CH, default 1, giving the number of input channels (must be >= 1).
REQ-003 The block SHALL have parameter PIPE_LAT, default 3, giving the cycles from a row issue to a valid array result (must be >= 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: begins one layer pass when sampled in IDLE.
REQ-007 The block SHALL have port w_load, output, 1 bit: one-cycle strobe that loads the filter and bias for channel w_ch.
REQ-008 The block SHALL have port w_ch, output, clog2(CH)+1 bits: current channel index.
REQ-009 The block SHALL have port if_rd_en, output, 1 bit: ifmap triple-row read enable.
REQ-010 The block SHALL have port if_row_addr, output, clog2(IMG_H) bits: top row r of the triple; the three array rows read r, r+1 and r+2.
REQ-011 The block SHALL have port ps_we, output, 1 bit: psum buffer write enable, aligned with valid toPsum.
REQ-012 The block SHALL have port ps_row_addr, output, clog2(IMG_H) bits: output row being written.
REQ-013 The block SHALL have port ps_acc, output, 1 bit: 1 means accumulate into the psum buffer, 0 means overwrite.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse at pass completion.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-017 IDLE SHALL go to LOAD_W on the next edge when start=1, clearing the channel count to 0.
REQ-018 LOAD_W SHALL last exactly 1 cycle with w_load=1, then go to STREAM.
REQ-019 STREAM SHALL issue NROW = IMG_H-2 consecutive cycles with if_rd_en=1 and if_row_addr = 0..NROW-1, then go to DRAIN.
REQ-020 DRAIN SHALL last exactly PIPE_LAT cycles, then go to LOAD_W if channel count < CH-1 (incrementing it), otherwise go to DONE.
REQ-021 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-022 Each issue SHALL push {valid, row, acc = (channel != 0)} into a PIPE_LAT-deep shift register.
REQ-023 ps_we, ps_row_addr and ps_acc SHALL be driven from the shift-register output, so ps_we follows if_rd_en by exactly PIPE_LAT cycles.
REQ-024 The last ps_we of each channel SHALL fall inside its DRAIN, so writes of consecutive channels never overlap.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 start held high through DONE SHALL begin a new pass only after one IDLE cycle.
REQ-027 When ps_we=0, ps_row_addr and ps_acc SHALL be 0.
REQ-028 When if_rd_en=0, if_row_addr SHALL be 0.
REQ-029 w_ch SHALL equal the channel count in every state and be 0 in IDLE.
REQ-030 Row and channel counters SHALL never wrap, since each terminal value forces a state exit.

Reset
REQ-031 On rst=1 at a clock edge, the state SHALL become IDLE, all counters and shift-register stages SHALL clear, and all outputs SHALL be 0 on the following cycle.
REQ-032 rst SHALL take priority over start and over any in-flight pass; an aborted pass SHALL produce no further ps_we and no done.

Configuration
REQ-033 With macro DONE_IRQ_EN defined, the block SHALL add input irq_clr (1 bit) and output irq (1 bit).
REQ-034 irq SHALL set on the cycle after done, SHALL stay set until irq_clr=1, and SHALL clear on rst.
REQ-035 If done and irq_clr coincide, irq SHALL set (set wins).
REQ-036 Without DONE_IRQ_EN, the irq_clr and irq ports SHALL be absent and there SHALL be no irq logic.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the shift-register entry type {valid, row, acc}, and the default constants 64, 1 and 3.
REQ-038 The PIPE_LAT shift register SHALL be a sub-module named ctrl_delay_line, with clk, rst, a shift-in entry and a shift-out entry.

Verification
REQ-039 Basic pass: IMG_H=8, CH=1, PIPE_LAT=3, start pulse sampled at cycle 0 -> w_load at cycle 1; if_rd_en at cycles 2-7 with rows 0-5; ps_we at cycles 5-10 with rows 0-5 and ps_acc=0; done at cycle 11; busy high for cycles 1-11.
REQ-040 Two channels: IMG_H=8, CH=2, PIPE_LAT=3 -> second w_load at cycle 11 with w_ch=1; ps_we at cycles 15-20 with ps_acc=1; done at cycle 21.
REQ-041 Start while busy: start held high for cycles 0-15 with CH=1 -> exactly one pass; the next LOAD_W occurs at cycle 13, after the IDLE cycle at 12.
REQ-042 Mid-stream reset: rst=1 at cycle 4 -> at cycle 5 all outputs are 0, and no ps_we or done appears through cycle 20.
REQ-043 Interrupt (DONE_IRQ_EN defined): irq rises at cycle 12; irq_clr at cycle 15 clears it at cycle 16; irq_clr coinciding with done leaves irq=1 afterwards.
REQ-044 Minimum size: IMG_H=3, CH=1, PIPE_LAT=1 -> a single issue at cycle 2, ps_we at cycle 3, done at cycle 4.
